// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory.
// An in-order owner-tag FIFO routes each memory response back to the port that issued it.
module mem_port_arbiter #(
  parameter int OP_WIDTH  = 68,
  parameter int TAG_DEPTH = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 p0_put_valid,
  output logic                 p0_put_ready,
  input  logic [OP_WIDTH-1:0]  p0_put_request,
  input  logic                 p0_get_valid,
  output logic                 p0_get_ready,
  output logic [OP_WIDTH-1:0]  p0_get_response,
  input  logic                 p1_put_valid,
  output logic                 p1_put_ready,
  input  logic [OP_WIDTH-1:0]  p1_put_request,
  input  logic                 p1_get_valid,
  output logic                 p1_get_ready,
  output logic [OP_WIDTH-1:0]  p1_get_response,
  output logic                 mem_put_valid,
  input  logic                 mem_put_ready,
  output logic [OP_WIDTH-1:0]  mem_put_request,
  output logic                 mem_get_valid,
  input  logic                 mem_get_ready,
  input  logic [OP_WIDTH-1:0]  mem_get_response,
  output logic [CNT_WIDTH-1:0] p0_grant_count,
  output logic [CNT_WIDTH-1:0] p1_grant_count,
  output logic                 protocol_error
);

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = $clog2(TAG_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);

  logic                 tag_q [TAG_DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] p0_cnt_q, p0_cnt_d;
  logic [CNT_WIDTH-1:0] p1_cnt_q, p1_cnt_d;
  logic                 err_q, err_d;

  logic empty, full, head, gnt_any, gnt_id, can_push, push, pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == FULL_CNT);
    head    = tag_q[rd_ptr_q];
    gnt_any = p0_put_valid | p1_put_valid;
    // On a tie the port that did not win last time goes next.
    if (p0_put_valid && p1_put_valid) gnt_id = ~last_grant_q;
    else                              gnt_id = p1_put_valid;
  end

  // Every handshake output is gated by RST_N so it drops the instant reset asserts.
  always_comb begin
    mem_get_valid   = RST_N && !empty && (head ? p1_get_valid : p0_get_valid);
    p0_get_ready    = RST_N && !empty && !head && mem_get_ready;
    p1_get_ready    = RST_N && !empty &&  head && mem_get_ready;
    p0_get_response = mem_get_response;
    p1_get_response = mem_get_response;
    pop             = mem_get_valid && mem_get_ready;
    can_push        = !full || pop;
    mem_put_valid   = RST_N && gnt_any && can_push;
    mem_put_request = gnt_id ? p1_put_request : p0_put_request;
    p0_put_ready    = mem_put_valid && !gnt_id && mem_put_ready;
    p1_put_ready    = mem_put_valid &&  gnt_id && mem_put_ready;
    push            = mem_put_valid && mem_put_ready;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    p0_cnt_d     = p0_cnt_q;
    p1_cnt_d     = p1_cnt_q;
    err_d        = err_q | (mem_get_ready && empty);
    if (push) begin
      wr_ptr_d     = wr_ptr_q + PW'(1);
      last_grant_d = gnt_id;
      if (gnt_id) p1_cnt_d = p1_cnt_q + CNT_WIDTH'(1);
      else        p0_cnt_d = p0_cnt_q + CNT_WIDTH'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      p0_cnt_q     <= '0;
      p1_cnt_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
      p0_cnt_q     <= p0_cnt_d;
      p1_cnt_q     <= p1_cnt_d;
      err_q        <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge CLK) begin
    if (push) tag_q[wr_ptr_q] <= gnt_id;
  end

  assign p0_grant_count = p0_cnt_q;
  assign p1_grant_count = p1_cnt_q;
  assign protocol_error = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a queue-based reference model
// plus a small word-addressed memory model acting as the downstream slave.
module tb_mem_port_arbiter;

  localparam int OPW = 68;
  localparam int TD  = 2;
  localparam int CNW = 32;

  logic           CLK = 1'b0;
  logic           RST_N = 1'b0;
  logic           p0_put_valid, p0_put_ready, p0_get_valid, p0_get_ready;
  logic           p1_put_valid, p1_put_ready, p1_get_valid, p1_get_ready;
  logic [OPW-1:0] p0_put_request, p0_get_response, p1_put_request, p1_get_response;
  logic           mem_put_valid, mem_put_ready, mem_get_valid, mem_get_ready;
  logic [OPW-1:0] mem_put_request, mem_get_response;
  logic [CNW-1:0] p0_grant_count, p1_grant_count;
  logic           protocol_error;

  mem_port_arbiter #(.OP_WIDTH(OPW), .TAG_DEPTH(TD), .CNT_WIDTH(CNW)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .p0_put_valid(p0_put_valid), .p0_put_ready(p0_put_ready), .p0_put_request(p0_put_request),
    .p0_get_valid(p0_get_valid), .p0_get_ready(p0_get_ready), .p0_get_response(p0_get_response),
    .p1_put_valid(p1_put_valid), .p1_put_ready(p1_put_ready), .p1_put_request(p1_put_request),
    .p1_get_valid(p1_get_valid), .p1_get_ready(p1_get_ready), .p1_get_response(p1_get_response),
    .mem_put_valid(mem_put_valid), .mem_put_ready(mem_put_ready), .mem_put_request(mem_put_request),
    .mem_get_valid(mem_get_valid), .mem_get_ready(mem_get_ready), .mem_get_response(mem_get_response),
    .p0_grant_count(p0_grant_count), .p1_grant_count(p1_grant_count),
    .protocol_error(protocol_error)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: owner order, pending memory responses, per-port expected responses.
  bit             own[$];
  logic [OPW-1:0] mq[$];
  logic [OPW-1:0] pq0[$];
  logic [OPW-1:0] pq1[$];
  bit             last_m;
  int unsigned    cnt_m[2];
  bit             err_m;
  logic [31:0]    mem_m [256];

  task automatic check_eq(input string tag, input logic [OPW-1:0] got, input logic [OPW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    own.delete(); mq.delete(); pq0.delete(); pq1.delete();
    last_m = 1'b1; cnt_m[0] = 0; cnt_m[1] = 0; err_m = 1'b0;
  endtask

  task automatic mem_access(input logic [OPW-1:0] op, output logic [OPW-1:0] rsp);
    logic [3:0]  be;
    logic [31:0] a, w;
    be = op[67:64];
    a  = op[63:32];
    w  = mem_m[a[9:2]];
    for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = op[8*b +: 8];
    mem_m[a[9:2]] = w;
    rsp = {be, a, w};
  endtask

  function automatic logic [OPW-1:0] rand_op();
    logic [3:0]  be;
    logic [31:0] a, d;
    be = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
    a  = {22'h0, 8'($urandom), 2'b00};
    d  = $urandom;
    return {be, a, d};
  endfunction

  function automatic logic [OPW-1:0] mk_op(input logic [3:0] be, input logic [31:0] a, input logic [31:0] d);
    return {be, a, d};
  endfunction

  task automatic drive_idle();
    p0_put_valid = 0; p1_put_valid = 0; p0_put_request = '0; p1_put_request = '0;
    p0_get_valid = 0; p1_get_valid = 0; mem_put_ready = 0; mem_get_ready = 0;
    mem_get_response = '0;
  endtask

  // One clock cycle: entered at posedge+1, drives, checks at negedge, updates model at posedge.
  task automatic step(input bit v0, input bit v1, input logic [OPW-1:0] r0, input logic [OPW-1:0] r1,
                      input bit gv0, input bit gv1, input bit mpr, input bit mgr_want, input bit force_err);
    bit have, head, mgr, mgv, pop, canp, any, g, mpv, pr0, pr1, gr0, gr1;
    logic [OPW-1:0] rsp;
    p0_put_valid = v0; p1_put_valid = v1; p0_put_request = r0; p1_put_request = r1;
    p0_get_valid = gv0; p1_get_valid = gv1; mem_put_ready = mpr;
    have = own.size() > 0;
    head = have ? own[0] : 1'b0;
    mgr  = force_err || (mgr_want && mq.size() > 0);
    mem_get_ready    = mgr;
    mem_get_response = (mq.size() > 0) ? mq[0] : {OPW{1'b0}};
    mgv  = have && (head ? gv1 : gv0);
    pop  = mgv && mgr;
    canp = (own.size() < TD) || pop;
    any  = v0 || v1;
    g    = (v0 && v1) ? !last_m : v1;
    mpv  = any && canp;
    pr0  = mpv && !g && mpr;
    pr1  = mpv && g && mpr;
    gr0  = have && !head && mgr;
    gr1  = have && head && mgr;
    @(negedge CLK);
    check_eq("mem_put_valid", OPW'(mem_put_valid), OPW'(mpv));
    check_eq("p0_put_ready", OPW'(p0_put_ready), OPW'(pr0));
    check_eq("p1_put_ready", OPW'(p1_put_ready), OPW'(pr1));
    if (mpv) check_eq("mem_put_request", mem_put_request, g ? r1 : r0);
    check_eq("mem_get_valid", OPW'(mem_get_valid), OPW'(mgv));
    check_eq("p0_get_ready", OPW'(p0_get_ready), OPW'(gr0));
    check_eq("p1_get_ready", OPW'(p1_get_ready), OPW'(gr1));
    if (gr0 && gv0 && pq0.size() > 0) check_eq("p0_get_response", p0_get_response, pq0[0]);
    if (gr1 && gv1 && pq1.size() > 0) check_eq("p1_get_response", p1_get_response, pq1[0]);
    check_eq("p0_grant_count", OPW'(p0_grant_count), OPW'(cnt_m[0]));
    check_eq("p1_grant_count", OPW'(p1_grant_count), OPW'(cnt_m[1]));
    check_eq("protocol_error", OPW'(protocol_error), OPW'(err_m));
    @(posedge CLK);
    if (mgr && !have) err_m = 1'b1;
    if (pop) begin
      void'(own.pop_front());
      void'(mq.pop_front());
      if (head) void'(pq1.pop_front());
      else      void'(pq0.pop_front());
    end
    if (mpv && mpr) begin
      own.push_back(g);
      last_m = g;
      cnt_m[g] = cnt_m[g] + 1;
      mem_access(g ? r1 : r0, rsp);
      mq.push_back(rsp);
      if (g) pq1.push_back(rsp);
      else   pq0.push_back(rsp);
    end
    #1;
  endtask

  task automatic drain();
    repeat (4) step(0, 0, '0, '0, 1, 1, 0, 1, 0);
  endtask

  task automatic do_reset();
    drive_idle();
    RST_N = 1'b0;
    #2;
    check_eq("rst_mem_put_valid", OPW'(mem_put_valid), '0);
    check_eq("rst_grant_counts", OPW'({p0_grant_count, p1_grant_count}), '0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_m[i] = 32'h0;
    model_reset();
    drive_idle();
    RST_N = 1'b0;
    #2;
    check_eq("init_put_readys", OPW'({p0_put_ready, p1_put_ready, mem_put_valid}), '0);
    check_eq("init_get_readys", OPW'({p0_get_ready, p1_get_ready, mem_get_valid}), '0);
    check_eq("init_counts", OPW'({p0_grant_count, p1_grant_count}), '0);
    check_eq("init_protocol_error", OPW'(protocol_error), '0);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;

    repeat (2) step(0, 0, '0, '0, 0, 0, 0, 0, 0);

    // p0 read of 0x100 returning 0xDEADBEEF on the next cycle.
    mem_m[8'h40] = 32'hDEADBEEF;
    step(1, 0, mk_op(4'h0, 32'h100, 32'h0), '0, 0, 0, 1, 0, 0);
    step(0, 0, '0, '0, 1, 0, 0, 1, 0);
    check_eq("p0_read_count", OPW'(p0_grant_count), OPW'(1));

    // Both ports valid for 8 grants: alternate starting with p0.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 1, rand_op(), rand_op(), 1, 1, 1, 1, 0);
    check_eq("rr_p0_count", OPW'(p0_grant_count), OPW'(4));
    check_eq("rr_p1_count", OPW'(p1_grant_count), OPW'(4));
    drain();

    // p1 write then p0 read of the same word: in-order routing and data.
    step(0, 1, '0, mk_op(4'hF, 32'h40, 32'h12345678), 1, 1, 1, 0, 0);
    step(1, 0, mk_op(4'h0, 32'h40, 32'h0), '0, 1, 1, 1, 1, 0);
    drain();

    // Stall p0's response while p1 fills the FIFO, then release for pop+push together.
    step(1, 0, mk_op(4'h0, 32'h80, 32'h0), '0, 0, 1, 1, 0, 0);
    step(0, 1, '0, rand_op(), 0, 1, 1, 1, 0);
    step(0, 1, '0, rand_op(), 0, 1, 1, 1, 0);
    step(0, 1, '0, rand_op(), 1, 1, 1, 1, 0);
    drain();

    // Response with no owner sets a sticky error.
    step(0, 0, '0, '0, 0, 0, 0, 0, 1);
    repeat (3) step(1, 1, rand_op(), rand_op(), 1, 1, 1, 1, 0);
    drain();
    check_eq("perr_sticky", OPW'(protocol_error), OPW'(1));

    // Asynchronous reset mid-operation with a response outstanding.
    step(1, 0, rand_op(), '0, 0, 0, 1, 0, 0);
    p0_put_valid = 1; p0_put_request = rand_op(); mem_put_ready = 1;
    p0_get_valid = 1; mem_get_ready = 1; mem_get_response = mq[0];
    #1;
    check_eq("pre_rst_put_valid", OPW'(mem_put_valid), OPW'(1));
    check_eq("pre_rst_get_valid", OPW'(mem_get_valid), OPW'(1));
    #1;
    RST_N = 1'b0;
    #1;
    check_eq("async_put", OPW'({mem_put_valid, p0_put_ready, p1_put_ready}), '0);
    check_eq("async_get", OPW'({mem_get_valid, p0_get_ready, p1_get_ready}), '0);
    check_eq("async_counts", OPW'({p0_grant_count, p1_grant_count}), '0);
    check_eq("async_perr", OPW'(protocol_error), '0);
    drive_idle();
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    model_reset();

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rand_op(), rand_op(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 0);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
